// File: rtl/icache_ctrl.sv
// Direct-mapped instruction cache controller.
// Hits return in the same cycle; misses refill one line word-by-word.
module icache_ctrl #(
    parameter int LINE_WORDS = 4,
    parameter int NUM_LINES  = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_req,
    input  logic [31:0] fetch_addr,
    output logic [31:0] fetch_data,
    output logic        fetch_valid,
    output logic        stall,
    input  logic        flush,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rdata,
    input  logic        mem_rvalid,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
);

    localparam int WS_W   = $clog2(LINE_WORDS);
    localparam int IDX_W  = $clog2(NUM_LINES);
    localparam int LINE_W = 30 - WS_W;
    localparam int TAG_W  = LINE_W - IDX_W;
    localparam logic [WS_W-1:0] LAST_WORD = WS_W'(LINE_WORDS - 1);

    typedef enum logic [1:0] {
        LOOKUP,
        REFILL,
        UPDATE
    } state_t;

    state_t                  state_q, state_d;
    logic [WS_W-1:0]         cnt_q, cnt_d;
    logic [LINE_W-1:0]       line_q, line_d;
    logic                    flush_pend_q, flush_pend_d;
    logic [NUM_LINES-1:0]    valid_q, valid_d;
    logic [31:0]             hit_q, hit_d;
    logic [31:0]             miss_q, miss_d;

    logic [TAG_W-1:0]        tag_q  [NUM_LINES];
    logic [31:0]             data_q [NUM_LINES][LINE_WORDS];

    logic                    tag_we;
    logic                    data_we;

    logic [TAG_W-1:0]        f_tag;
    logic [IDX_W-1:0]        f_idx;
    logic [WS_W-1:0]         f_ws;
    logic [IDX_W-1:0]        r_idx;
    logic [TAG_W-1:0]        r_tag;
    logic                    hit;
    logic                    unused_addr_bits;

    assign f_tag = fetch_addr[31 -: TAG_W];
    assign f_idx = fetch_addr[2+WS_W +: IDX_W];
    assign f_ws  = fetch_addr[2 +: WS_W];
    assign r_idx = line_q[IDX_W-1:0];
    assign r_tag = line_q[LINE_W-1 -: TAG_W];
    assign unused_addr_bits = ^fetch_addr[1:0];

    assign hit = valid_q[f_idx] && (tag_q[f_idx] == f_tag);

    // Fetch-side outputs; gated by rst so they drop the instant reset asserts.
    assign fetch_valid = !rst && (state_q == LOOKUP) && fetch_req && hit;
    assign fetch_data  = fetch_valid ? data_q[f_idx][f_ws] : 32'h0;
    assign stall       = !rst && fetch_req && !fetch_valid;
    assign mem_req     = !rst && (state_q == REFILL);
    assign mem_addr    = {line_q, cnt_q, 2'b00};
    assign hit_count   = hit_q;
    assign miss_count  = miss_q;

    // Next-state logic for the lookup/refill/update sequence.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        line_d       = line_q;
        flush_pend_d = flush_pend_q;
        valid_d      = valid_q;
        hit_d        = hit_q;
        miss_d       = miss_q;
        tag_we       = 1'b0;
        data_we      = 1'b0;
        unique case (state_q)
            LOOKUP: begin
                if (fetch_req && hit) begin
                    hit_d = hit_q + 32'd1;
                end else if (fetch_req && !flush) begin
                    line_d  = fetch_addr[31 -: LINE_W];
                    miss_d  = miss_q + 32'd1;
                    cnt_d   = '0;
                    state_d = REFILL;
                end
                if (flush) begin
                    valid_d = '0;
                end
            end
            REFILL: begin
                if (flush) begin
                    flush_pend_d = 1'b1;
                end
                if (mem_rvalid) begin
                    data_we = 1'b1;
                    if (cnt_q == LAST_WORD) begin
                        state_d = UPDATE;
                    end else begin
                        cnt_d = cnt_q + WS_W'(1);
                    end
                end
            end
            UPDATE: begin
                tag_we = 1'b1;
                if (flush_pend_q || flush) begin
                    valid_d      = '0;
                    flush_pend_d = 1'b0;
                end else begin
                    valid_d[r_idx] = 1'b1;
                end
                state_d = LOOKUP;
            end
            default: begin
                state_d = LOOKUP;
            end
        endcase
    end

    // Control state, valid bits and performance counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= LOOKUP;
            cnt_q        <= '0;
            line_q       <= '0;
            flush_pend_q <= 1'b0;
            valid_q      <= '0;
            hit_q        <= '0;
            miss_q       <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            line_q       <= line_d;
            flush_pend_q <= flush_pend_d;
            valid_q      <= valid_d;
            hit_q        <= hit_d;
            miss_q       <= miss_d;
        end
    end

    // Tag and data storage; contents are meaningless until the valid bit is set.
    always_ff @(posedge clk) begin
        if (data_we) begin
            data_q[r_idx][cnt_q] <= mem_rdata;
        end
        if (tag_we) begin
            tag_q[r_idx] <= r_tag;
        end
    end

endmodule
